multiword_add_sequencer: RTL and testbench

//  Sequences one shared N-bit adder (DataFlowPrefixAdd-class, a/b/ci -> c/co) to add or subtract

---
 rtl/multiword_add_sequencer.sv | 119 +++++++++++
 tb/tb_multiword_add_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer: walks WORDS N-bit slices through one external
// adder, LSW first, chaining the carry through a register between words.
module multiword_add_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   in_a,
    input  logic [N*WORDS-1:0]   in_b,
    input  logic                 in_ci,
    input  logic                 in_sub,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_ci,
    input  logic [N-1:0]         add_c,
    input  logic                 add_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_co
);

    // state   | meaning
    // S_IDLE  | waiting for a request, in_ready=1
    // S_RUN   | one word per cycle through the adder, idx 0..WORDS-1
    // S_DONE  | result held on out_sum/out_co until out_ready

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_ci    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction folds into addition: A + ~B + 1.
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_ci;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_q[idx_q*N +: N];
                add_b   = b_q[idx_q*N +: N];
                add_ci  = carry_q;
                sum_d[idx_q*N +: N] = add_c;
                carry_d = add_co;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_sum = sum_q;
    assign out_co  = carry_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (N=8, WORDS=4): directed cases plus random traffic,
// every cycle compared against a whole-operand arithmetic model.
module tb_multiword_add_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         in_sub;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_ci;
    logic [N-1:0] add_c;
    logic         add_co;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_c     (add_c),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
    );

    // External adder stand-in.
    logic [N:0] add_res;
    assign add_res = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_ci};
    assign add_c   = add_res[N-1:0];
    assign add_co  = add_res[N];

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..WORDS running word phase-1, WORDS+1 done.
    int           phase   = 0;
    int           cyc     = 0;
    bit           started = 0;
    bit           m_rst   = 0;
    logic [63:0]  ma, mb;
    logic         mc;
    logic [W-1:0] m_sum;
    logic         m_co;
    logic [W:0]   tot;
    int           acc_cyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        m_rst = rst;
        if (rst) begin
            phase = 0;
            m_sum = '0;
            m_co  = 1'b0;
        end else if (phase == 0) begin
            if (in_valid) begin
                ma    = {32'b0, in_a};
                mb    = {32'b0, (in_sub ? ~in_b : in_b)};
                mc    = in_sub ? 1'b1 : in_ci;
                phase = 1;
                acc_cyc.push_back(cyc);
            end
        end else if (phase <= WORDS) begin
            if (phase == WORDS) begin
                tot   = ma[W:0] + mb[W:0] + {{W{1'b0}}, mc};
                m_sum = tot[W-1:0];
                m_co  = tot[W];
            end
            phase++;
        end else if (out_ready) begin
            phase = 0;
        end
        started = 1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, (phase == 0)});
            chk("out_valid", {63'b0, out_valid}, {63'b0, (phase == WORDS + 1)});
            if (phase == WORDS + 1) begin
                chk("out_sum", {32'b0, out_sum}, {32'b0, m_sum});
                chk("out_co", {63'b0, out_co}, {63'b0, m_co});
            end
            if (m_rst) begin
                chk("rst_out_sum", {32'b0, out_sum}, 64'd0);
                chk("rst_out_co", {63'b0, out_co}, 64'd0);
            end
            if (phase >= 1 && phase <= WORDS) begin
                int k;
                logic [63:0] mask, cin;
                k    = phase - 1;
                mask = (64'd1 << (k * N)) - 64'd1;
                cin  = ((ma & mask) + (mb & mask) + {63'b0, mc}) >> (k * N);
                chk("add_a", {56'b0, add_a}, (ma >> (k * N)) & 64'hFF);
                chk("add_b", {56'b0, add_b}, (mb >> (k * N)) & 64'hFF);
                chk("add_ci", {63'b0, add_ci}, cin & 64'd1);
            end else begin
                chk("add_idle", {47'b0, add_a, add_b, add_ci}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE; returns at the first cycle out_valid is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, output int lat, output int ci_cnt,
                         output logic [W-1:0] sum, output logic co);
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        ci_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (add_ci) ci_cnt++;
            step();
            lat++;
        end
        if (!out_valid) chk("op_timeout", 64'd0, 64'd1);
        sum = out_sum;
        co  = out_co;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (phase != 0 && n < 30) begin
            step();
            n++;
        end
        if (phase != 0) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int           lat, cic, base, n;
        logic [W-1:0] s, held_s;
        logic         c, held_c;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_out_sum", {32'b0, out_sum}, 64'd0);
        chk("reset_add", {47'b0, add_a, add_b, add_ci}, 64'd0);

        // 1: carry across a word boundary
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, cic, s, c);
        chk("t1_latency", lat, 64'd4);
        chk("t1_sum", {32'b0, s}, 64'h00000100);
        chk("t1_co", {63'b0, c}, 64'd0);
        chk("t1_model_sum", {32'b0, m_sum}, 64'h00000100);
        wait_idle();

        // 2: carry-in ripples through every word
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat, cic, s, c);
        chk("t2_sum", {32'b0, s}, 64'h00000000);
        chk("t2_co", {63'b0, c}, 64'd1);
        chk("t2_ci_cycles", cic, 64'd4);
        chk("t2_model_co", {63'b0, m_co}, 64'd1);
        wait_idle();

        // 3: subtraction with and without borrow (in_ci must be ignored)
        do_op(32'h00000000, 32'h00000001, 1'b1, 1'b1, lat, cic, s, c);
        chk("t3a_sum", {32'b0, s}, 64'hFFFFFFFF);
        chk("t3a_co", {63'b0, c}, 64'd0);
        chk("t3a_model_sum", {32'b0, m_sum}, 64'hFFFFFFFF);
        wait_idle();
        do_op(32'h00000005, 32'h00000003, 1'b0, 1'b1, lat, cic, s, c);
        chk("t3b_sum", {32'b0, s}, 64'h00000002);
        chk("t3b_co", {63'b0, c}, 64'd1);
        wait_idle();

        // 4: result held under backpressure, requests ignored
        out_ready = 1'b0;
        do_op(32'h89ABCDEF, 32'h76543211, 1'b0, 1'b0, lat, cic, held_s, held_c);
        chk("t4_sum", {32'b0, held_s}, 64'h00000000);
        chk("t4_co", {63'b0, held_c}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = $urandom; in_b = $urandom;
            step();
            chk("t4_hold_sum", {32'b0, out_sum}, {32'b0, held_s});
            chk("t4_hold_valid", {63'b0, out_valid}, 64'd1);
            chk("t4_hold_ready", {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_release_ready", {63'b0, in_ready}, 64'd1);
        chk("t4_release_valid", {63'b0, out_valid}, 64'd0);

        // 5: reset on the 2nd RUN edge aborts the op
        in_a = 32'hDEADBEEF; in_b = 32'h01010101; in_sub = 1'b0; in_ci = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_in_ready", {63'b0, in_ready}, 64'd1);
        chk("t5_out_valid", {63'b0, out_valid}, 64'd0);
        chk("t5_out_sum", {32'b0, out_sum}, 64'd0);
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat, cic, s, c);
        chk("t5_latency", lat, 64'd4);
        chk("t5_sum", {32'b0, s}, 64'h23456789);
        wait_idle();

        // 6: back-to-back with in_valid and out_ready held high
        base = acc_cyc.size();
        in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom); in_sub = 1'($urandom);
        in_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < base + 3 && n < 40) begin
            step();
            n++;
            if (phase == 1) begin
                in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom); in_sub = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        if (acc_cyc.size() < base + 3) begin
            chk("t6_accept_timeout", 64'd0, 64'd1);
        end else begin
            chk("t6_gap1", acc_cyc[base+1] - acc_cyc[base], 64'd6);
            chk("t6_gap2", acc_cyc[base+2] - acc_cyc[base+1], 64'd6);
        end
        wait_idle();

        // Random traffic: stalls, sporadic requests and occasional resets.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_a = $urandom; in_b = $urandom;
            in_ci = 1'($urandom); in_sub = 1'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
